// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the I2C read arbiter.
package iic_arb_pkg;

    localparam int unsigned DevAddrW = 7;
    localparam int unsigned RegAddrW = 16;
    localparam int unsigned LenW     = 8;
    localparam int unsigned RDataW   = 32;
    localparam int unsigned MAX_LEN  = 4;

    typedef enum logic [2:0] {
        StInit,
        StInitWait,
        StArb,
        StIssue,
        StBusy,
        StDone
    } arb_state_e;

    // A read is issuable only for 1..MAX_LEN bytes; anything else is rejected with an error.
    function automatic logic len_valid(input logic [LenW-1:0] len);
        return (len != '0) && (len <= LenW'(MAX_LEN));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after pointer wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan requesters in priority order starting at pointer, wrapping past NUM_REQ-1.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(pointer) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/iic_read_arbiter.sv
// Arbitrates register-read requests from several clients onto one I2C front-end.
// One transaction at a time; a front-end timeout forces a re-init before arbitration resumes.
module iic_read_arbiter
    import iic_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         resetn,
    // requester side
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [DevAddrW*NUM_REQ-1:0]  i_dev_addr,
    input  logic [RegAddrW*NUM_REQ-1:0]  i_reg_addr,
    input  logic [LenW*NUM_REQ-1:0]      i_len,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic [NUM_REQ-1:0]           o_done,
    output logic                         o_err,
    output logic [RDataW-1:0]            o_rdata,
    // front-end side
    output logic [DevAddrW-1:0]          o_device_addr,
    output logic [RegAddrW-1:0]          o_reg_addr,
    output logic                         o_init_wstrobe,
    output logic [LenW-1:0]              o_read_len,
    output logic                         o_read_len_wstrobe,
    input  logic                         i_iic_idle,
    input  logic [RDataW-1:0]            i_iic_rx_data
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    winner_q, winner_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  recover_q, recover_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  err_q, err_d;
    logic [RDataW-1:0]     rdata_q, rdata_d;
    logic [DevAddrW-1:0]   dev_q, dev_d;
    logic [RegAddrW-1:0]   reg_q, reg_d;
    logic [LenW-1:0]       len_q, len_d;
    logic                  init_stb_q, init_stb_d;
    logic                  rd_stb_q, rd_stb_d;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IdxW-1:0]       arb_index;

    logic [DevAddrW-1:0]   dev_arr [NUM_REQ];
    logic [RegAddrW-1:0]   reg_arr [NUM_REQ];
    logic [LenW-1:0]       len_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign dev_arr[k] = i_dev_addr[k*DevAddrW +: DevAddrW];
        assign reg_arr[k] = i_reg_addr[k*RegAddrW +: RegAddrW];
        assign len_arr[k] = i_len[k*LenW +: LenW];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_arbiter (
        .req     (i_req),
        .pointer (ptr_q),
        .grant   (arb_grant),
        .index   (arb_index)
    );

    // Next-state and next-output logic; strobes, grant and done are single-cycle pulses.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        cnt_d      = cnt_q;
        recover_d  = recover_q;
        grant_d    = '0;
        done_d     = '0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        len_d      = len_q;
        init_stb_d = 1'b0;
        rd_stb_d   = 1'b0;

        case (state_q)
            StInit: begin
                if (i_iic_idle) begin
                    init_stb_d = 1'b1;
                    state_d    = StInitWait;
                end
            end
            StInitWait: begin
                // Idle drops during the strobe cycle itself, so only trust it afterwards.
                if (!init_stb_q && i_iic_idle) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (|i_req) begin
                    grant_d  = arb_grant;
                    winner_d = arb_grant;
                    dev_d    = dev_arr[arb_index];
                    reg_d    = reg_arr[arb_index];
                    len_d    = len_arr[arb_index];
                    if (arb_index == IdxW'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = arb_index + IdxW'(1);
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (len_valid(len_q)) begin
                    rd_stb_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end else begin
                    done_d  = winner_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StBusy: begin
                if (!rd_stb_q && i_iic_idle) begin
                    done_d  = winner_q;
                    err_d   = 1'b0;
                    rdata_d = i_iic_rx_data;
                    state_d = StDone;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    done_d    = winner_q;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    recover_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                // o_done is high during this state; a hung front-end gets re-initialised.
                if (recover_q) begin
                    recover_d = 1'b0;
                    state_d   = StInit;
                end else begin
                    state_d = StArb;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StInit;
            ptr_q      <= '0;
            winner_q   <= '0;
            cnt_q      <= '0;
            recover_q  <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            dev_q      <= '0;
            reg_q      <= '0;
            len_q      <= '0;
            init_stb_q <= 1'b0;
            rd_stb_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            cnt_q      <= cnt_d;
            recover_q  <= recover_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            len_q      <= len_d;
            init_stb_q <= init_stb_d;
            rd_stb_q   <= rd_stb_d;
        end
    end

    assign o_grant            = grant_q;
    assign o_done             = done_q;
    assign o_err              = err_q;
    assign o_rdata            = rdata_q;
    assign o_device_addr      = dev_q;
    assign o_reg_addr         = reg_q;
    assign o_init_wstrobe     = init_stb_q;
    assign o_read_len         = len_q;
    assign o_read_len_wstrobe = rd_stb_q;

endmodule

// File: tb/tb_iic_read_arbiter.sv
// Self-checking bench for iic_read_arbiter with a behavioural I2C front-end model.
module tb_iic_read_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 100;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [N-1:0]     i_req = '0;
    logic [7*N-1:0]   i_dev_addr = '0;
    logic [16*N-1:0]  i_reg_addr = '0;
    logic [8*N-1:0]   i_len = '0;
    logic [N-1:0]     o_grant, o_done;
    logic             o_err;
    logic [31:0]      o_rdata;
    logic [6:0]       o_device_addr;
    logic [15:0]      o_reg_addr;
    logic             o_init_wstrobe, o_read_len_wstrobe;
    logic [7:0]       o_read_len;
    logic             i_iic_idle;
    logic [31:0]      i_iic_rx_data;

    iic_read_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .i_req              (i_req),
        .i_dev_addr         (i_dev_addr),
        .i_reg_addr         (i_reg_addr),
        .i_len              (i_len),
        .o_grant            (o_grant),
        .o_done             (o_done),
        .o_err              (o_err),
        .o_rdata            (o_rdata),
        .o_device_addr      (o_device_addr),
        .o_reg_addr         (o_reg_addr),
        .o_init_wstrobe     (o_init_wstrobe),
        .o_read_len         (o_read_len),
        .o_read_len_wstrobe (o_read_len_wstrobe),
        .i_iic_idle         (i_iic_idle),
        .i_iic_rx_data      (i_iic_rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Front-end model: busy for a while after each strobe, idle drops combinationally on strobes.
    logic        fe_hang = 1'b0;
    int          fe_busy = 3;
    int          fe_cnt = 0;
    bit          fe_rand = 1'b1;
    logic [31:0] fe_next = '0;
    logic [31:0] fe_data = '0;

    always @(posedge clk) begin
        if (o_read_len_wstrobe) begin
            fe_cnt  <= fe_busy;
            fe_data <= fe_rand ? $urandom : fe_next;
        end else if (o_init_wstrobe) begin
            fe_cnt <= 2;
        end else if (fe_cnt > 0) begin
            fe_cnt <= fe_cnt - 1;
        end
    end

    assign i_iic_idle    = !fe_hang && (fe_cnt == 0) && !o_init_wstrobe && !o_read_len_wstrobe;
    assign i_iic_rx_data = fe_data;

    // Event monitor: counts and time stamps used by the scenario tasks.
    int   init_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int   init_cyc = 0, rd_cyc = 0, idle_rise_cyc = 0;
    int   both_hi = 0, bad_oh = 0, overlap = 0;
    bit   outstanding = 1'b0;
    logic idle_prev = 1'b0;

    always @(negedge clk) begin
        idle_prev <= i_iic_idle;
        if (i_iic_idle && !idle_prev) idle_rise_cyc <= cyc;
        if (o_init_wstrobe) begin
            init_cnt <= init_cnt + 1;
            init_cyc <= cyc;
        end
        if (o_read_len_wstrobe) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc <= cyc;
        end
        if (o_done != '0) done_cnt <= done_cnt + 1;
        if (o_init_wstrobe && o_read_len_wstrobe) both_hi <= both_hi + 1;
        if (o_grant != '0 && !$onehot(o_grant)) bad_oh <= bad_oh + 1;
        if (!resetn) begin
            outstanding <= 1'b0;
        end else if (o_grant != '0) begin
            if (outstanding) overlap <= overlap + 1;
            outstanding <= 1'b1;
        end else if (o_done != '0) begin
            if (!outstanding) overlap <= overlap + 1;
            outstanding <= 1'b0;
        end
    end

    // Reference state: round-robin priority start and per-requester arguments.
    int          n_cmp = 0, n_bad = 0;
    int          rr_ptr = 0;
    logic [6:0]  dev_a [N];
    logic [15:0] reg_a [N];
    logic [7:0]  len_a [N];

    function automatic int exp_winner(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_args();
        for (int k = 0; k < N; k++) begin
            i_dev_addr[k*7 +: 7]   = dev_a[k];
            i_reg_addr[k*16 +: 16] = reg_a[k];
            i_len[k*8 +: 8]        = len_a[k];
        end
    endtask

    task automatic rand_args(input int k);
        dev_a[k] = 7'($urandom);
        reg_a[k] = 16'($urandom);
        len_a[k] = 8'($urandom_range(1, 4));
    endtask

    task automatic wait_grant(input int limit, output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (o_grant != '0) begin
                ok = 1'b1;
                for (int k = 0; k < N; k++) if (o_grant[k]) idx = k;
                return;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (o_done != '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int idx, k, i0;
        bit ok;
        resetn = 1'b0;
        i_req  = '0;
        repeat (3) tick();
        n_cmp++;
        if (o_grant !== '0 || o_done !== '0 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_handshake: grant=%h done=%h err=%b want 0", o_grant, o_done, o_err);
        end
        n_cmp++;
        if (o_init_wstrobe !== 1'b0 || o_read_len_wstrobe !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: init=%b rd=%b want 0", o_init_wstrobe, o_read_len_wstrobe);
        end
        n_cmp++;
        if (o_rdata !== '0 || o_device_addr !== '0 || o_reg_addr !== '0 || o_read_len !== '0) begin
            n_bad++;
            $display("FAIL reset_data: rdata=%h dev=%h reg=%h len=%h want 0",
                     o_rdata, o_device_addr, o_reg_addr, o_read_len);
        end
        rr_ptr = 0;
        k = $urandom_range(0, N - 1);
        rand_args(k);
        apply_args();
        fe_busy = 4;
        i_req[k] = 1'b1;
        i0 = init_cnt;
        resetn = 1'b1;
        wait_grant(30, idx, ok);
        i_req = '0;
        n_cmp++;
        if (!ok || idx != exp_winner(N'(1) << k)) begin
            n_bad++;
            $display("FAIL post_reset_grant: got idx %0d want %0d", idx, k);
        end
        n_cmp++;
        if (init_cnt - i0 != 1) begin
            n_bad++;
            $display("FAIL init_before_grant: got %0d init strobes want 1", init_cnt - i0);
        end
        rr_ptr = (k + 1) % N;
        wait_done(40, ok);
        n_cmp++;
        if (!ok || o_done !== N'(1) << k || o_err !== 1'b0 || o_rdata !== fe_data) begin
            n_bad++;
            $display("FAIL post_reset_done: done=%h err=%b rdata=%h want %h/0/%h",
                     o_done, o_err, o_rdata, N'(1) << k, fe_data);
        end
        repeat (3) tick();
    endtask

    task automatic test_single();
        int idx, t, r0;
        bit ok;
        dev_a[2] = 7'h50;
        reg_a[2] = 16'h0010;
        len_a[2] = 8'd2;
        apply_args();
        fe_busy = 9;
        fe_rand = 1'b0;
        fe_next = 32'h0000ABCD;
        r0 = rd_cnt;
        t  = cyc;
        i_req = 4'b0100;
        wait_grant(10, idx, ok);
        i_req = '0;
        n_cmp++;
        if (!ok || o_grant !== 4'b0100 || cyc != t + 1) begin
            n_bad++;
            $display("FAIL single_grant: grant=%h at +%0d want 0100 at +1", o_grant, cyc - t);
        end
        n_cmp++;
        if (o_device_addr !== 7'h50 || o_reg_addr !== 16'h0010 || o_read_len !== 8'd2) begin
            n_bad++;
            $display("FAIL single_args: dev=%h reg=%h len=%0d want 50/0010/2",
                     o_device_addr, o_reg_addr, o_read_len);
        end
        rr_ptr = 3;
        tick();
        n_cmp++;
        if (o_read_len_wstrobe !== 1'b1 || cyc != t + 2 || o_read_len !== 8'd2) begin
            n_bad++;
            $display("FAIL single_strobe: stb=%b at +%0d len=%0d want 1 at +2 len 2",
                     o_read_len_wstrobe, cyc - t, o_read_len);
        end
        wait_done(40, ok);
        n_cmp++;
        if (!ok || o_done !== 4'b0100 || o_err !== 1'b0 || o_rdata !== 32'h0000ABCD) begin
            n_bad++;
            $display("FAIL single_done: done=%h err=%b rdata=%h want 0100/0/0000abcd",
                     o_done, o_err, o_rdata);
        end
        n_cmp++;
        if (cyc != idle_rise_cyc + 1 || rd_cnt - r0 != 1) begin
            n_bad++;
            $display("FAIL single_latency: done %0d cyc after idle, %0d strobes want 1/1",
                     cyc - idle_rise_cyc, rd_cnt - r0);
        end
        repeat (4) tick();
        n_cmp++;
        if (o_rdata !== 32'h0000ABCD) begin
            n_bad++;
            $display("FAIL rdata_hold: got %h want 0000abcd", o_rdata);
        end
        fe_rand = 1'b1;
    endtask

    task automatic test_round_robin();
        int idx, exp, r0, rg, i0;
        bit ok;
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        rr_ptr = 0;
        for (int k = 0; k < N; k++) rand_args(k);
        apply_args();
        fe_busy = $urandom_range(1, 8);
        r0 = rd_cnt;
        i0 = init_cnt;
        i_req = '1;
        for (int g = 0; g < 5; g++) begin
            exp = exp_winner('1);
            wait_grant(60, idx, ok);
            rg = rd_cnt;
            n_cmp++;
            if (!ok || idx != exp) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", g, idx, exp);
            end
            n_cmp++;
            if (o_device_addr !== dev_a[exp] || o_reg_addr !== reg_a[exp] ||
                o_read_len !== len_a[exp]) begin
                n_bad++;
                $display("FAIL rr_args[%0d]: dev=%h reg=%h len=%h want %h/%h/%h", g,
                         o_device_addr, o_reg_addr, o_read_len, dev_a[exp], reg_a[exp], len_a[exp]);
            end
            rr_ptr = (exp + 1) % N;
            wait_done(60, ok);
            if (g == 4) i_req = '0;
            n_cmp++;
            if (!ok || o_done !== N'(1) << exp || o_err !== 1'b0 || o_rdata !== fe_data ||
                rd_cnt - rg != 1) begin
                n_bad++;
                $display("FAIL rr_done[%0d]: done=%h err=%b rdata=%h strobes=%0d want %h/0/%h/1",
                         g, o_done, o_err, o_rdata, rd_cnt - rg, N'(1) << exp, fe_data);
            end
        end
        repeat (4) tick();
        n_cmp++;
        if (rd_cnt - r0 != 5 || init_cnt - i0 != 1) begin
            n_bad++;
            $display("FAIL rr_totals: rd=%0d init=%0d want 5/1", rd_cnt - r0, init_cnt - i0);
        end
    endtask

    task automatic test_bad_len();
        int idx, k, r0;
        bit ok;
        for (int c = 0; c < 2; c++) begin
            k = $urandom_range(0, N - 1);
            rand_args(k);
            len_a[k] = (c == 0) ? 8'd0 : 8'($urandom_range(5, 255));
            apply_args();
            r0 = rd_cnt;
            i_req[k] = 1'b1;
            wait_grant(10, idx, ok);
            i_req = '0;
            n_cmp++;
            if (!ok || idx != exp_winner(N'(1) << k)) begin
                n_bad++;
                $display("FAIL badlen_grant[%0d]: got %0d want %0d", c, idx, k);
            end
            rr_ptr = (k + 1) % N;
            wait_done(10, ok);
            n_cmp++;
            if (!ok || o_done !== N'(1) << k || o_err !== 1'b1 || o_rdata !== '0 ||
                rd_cnt != r0) begin
                n_bad++;
                $display("FAIL badlen_done[%0d]: done=%h err=%b rdata=%h strobes=%0d want %h/1/0/0",
                         c, o_done, o_err, o_rdata, rd_cnt - r0, N'(1) << k);
            end
            repeat (2) tick();
        end
    endtask

    task automatic test_timeout();
        int idx, k, s, i0;
        bit ok;
        k = $urandom_range(0, N - 1);
        rand_args(k);
        apply_args();
        fe_hang = 1'b1;
        i_req[k] = 1'b1;
        wait_grant(10, idx, ok);
        i_req = '0;
        rr_ptr = (k + 1) % N;
        tick();
        s = cyc;
        n_cmp++;
        if (!ok || idx != k || o_read_len_wstrobe !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_issue: idx=%0d stb=%b want %0d/1", idx, o_read_len_wstrobe, k);
        end
        wait_done(TMO + 50, ok);
        n_cmp++;
        if (!ok || o_done !== N'(1) << k || o_err !== 1'b1 || o_rdata !== '0 || cyc - s != TMO) begin
            n_bad++;
            $display("FAIL tmo_done: done=%h err=%b rdata=%h after %0d want %h/1/0 after %0d",
                     o_done, o_err, o_rdata, cyc - s, N'(1) << k, TMO);
        end
        fe_hang = 1'b0;
        i0 = init_cnt;
        k = $urandom_range(0, N - 1);
        i_req[k] = 1'b1;
        wait_grant(30, idx, ok);
        i_req = '0;
        n_cmp++;
        if (!ok || idx != exp_winner(N'(1) << k) || init_cnt - i0 != 1) begin
            n_bad++;
            $display("FAIL tmo_recover: idx=%0d inits=%0d want %0d/1", idx, init_cnt - i0, k);
        end
        rr_ptr = (k + 1) % N;
        wait_done(30, ok);
        n_cmp++;
        if (!ok || o_err !== 1'b0 || o_rdata !== fe_data) begin
            n_bad++;
            $display("FAIL tmo_next: err=%b rdata=%h want 0/%h", o_err, o_rdata, fe_data);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int idx, k, d0, i0;
        bit ok;
        k = $urandom_range(0, N - 1);
        rand_args(k);
        apply_args();
        fe_busy = 30;
        i_req[k] = 1'b1;
        wait_grant(10, idx, ok);
        repeat (6) tick();
        d0 = done_cnt;
        resetn = 1'b0;
        repeat (2) tick();
        rr_ptr = 0;
        i0 = init_cnt;
        resetn = 1'b1;
        wait_grant(80, idx, ok);
        i_req = '0;
        n_cmp++;
        if (!ok || idx != exp_winner(N'(1) << k) || init_cnt - i0 != 1) begin
            n_bad++;
            $display("FAIL midrst_regrant: idx=%0d inits=%0d want %0d/1", idx, init_cnt - i0, k);
        end
        n_cmp++;
        if (done_cnt != d0) begin
            n_bad++;
            $display("FAIL midrst_no_done: got %0d done pulses want 0", done_cnt - d0);
        end
        fe_busy = 3;
        wait_done(60, ok);
        n_cmp++;
        if (!ok || o_done !== N'(1) << k || o_err !== 1'b0 || o_rdata !== fe_data) begin
            n_bad++;
            $display("FAIL midrst_served: done=%h err=%b rdata=%h want %h/0/%h",
                     o_done, o_err, o_rdata, N'(1) << k, fe_data);
        end
        repeat (2) tick();
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (both_hi != 0 || bad_oh != 0 || overlap != 0) begin
            n_bad++;
            $display("FAIL invariants: both_strobes=%0d non_onehot=%0d overlap=%0d want 0/0/0",
                     both_hi, bad_oh, overlap);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) rand_args(k);
        apply_args();
        test_reset();
        test_single();
        test_round_robin();
        test_bad_len();
        test_timeout();
        test_reset_mid();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
